// File: rtl/dcache_sram_nway_pkg.sv
// dcache_sram_nway: shared defaults and line-state record.
// Tag field is sized for the widest supported tag; unused bits stay zero.
package dcache_pkg;

  localparam int DEF_SETS   = 16;
  localparam int DEF_WAYS   = 2;
  localparam int DEF_TAG_W  = 25;
  localparam int DEF_LINE_W = 256;
  localparam int TAG_MAX    = 64;

  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } line_t;

endpackage

// File: rtl/dcache_sram_nway_if.sv
// dcache_sram_nway: controller <-> storage array access bundle.
// master = dcache controller, slave = storage array.
interface dcache_sram_nway_if
  import dcache_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int WAYS   = DEF_WAYS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W
);

  localparam int IDX_W = $clog2(SETS);
  localparam int AGE_W = $clog2(WAYS);

  logic [IDX_W-1:0]  addr_i;
  logic [TAG_W-1:0]  tag_i;
  logic [LINE_W-1:0] data_i;
  logic              enable_i;
  logic              write_i;
  logic              dirty_i;
  logic              hit_o;
  logic [AGE_W-1:0]  way_o;
  logic [TAG_W-1:0]  tag_o;
  logic [LINE_W-1:0] data_o;
  logic              valid_o;
  logic              dirty_o;

  modport master (
    output addr_i, tag_i, data_i,
    output enable_i, write_i, dirty_i,
    input  hit_o, way_o, tag_o,
    input  data_o, valid_o, dirty_o
  );

  modport slave (
    input  addr_i, tag_i, data_i,
    input  enable_i, write_i, dirty_i,
    output hit_o, way_o, tag_o,
    output data_o, valid_o, dirty_o
  );

endinterface

// File: rtl/dcache_sram_nway_lru_age.sv
// dcache_sram_nway: per-set age counter update and oldest-way finder.
// Age 0 = most recently used, WAYS-1 = least recently used.
module dcache_lru_age #(
  parameter int WAYS = 2,
  localparam int AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] age_i,
  input  logic [AGE_W-1:0]           way_i,
  input  logic                       touch_i,
  output logic [WAYS-1:0][AGE_W-1:0] age_o,
  output logic [AGE_W-1:0]           oldest_o
);

  // Touched way becomes youngest; younger ways age by one.
  always_comb begin
    age_o = age_i;
    if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (AGE_W'(w) == way_i)
          age_o[w] = '0;
        else if (age_i[w] < age_i[way_i])
          age_o[w] = age_i[w] + AGE_W'(1);
      end
    end
  end

  // Locate the way holding the maximum age.
  always_comb begin
    oldest_o = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_i[w] == AGE_W'(WAYS - 1))
        oldest_o = AGE_W'(w);
    end
  end

endmodule

// File: rtl/dcache_sram_nway.sv
// dcache_sram_nway: N-way set-associative line store with true LRU.
// Lookup is combinational; fills and hit updates commit on clk_i.
module dcache_sram_nway
  import dcache_pkg::*;
#(
  parameter int SETS   = DEF_SETS,
  parameter int WAYS   = DEF_WAYS,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int LINE_W = DEF_LINE_W,
  localparam int IDX_W = $clog2(SETS),
  localparam int AGE_W = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dcache_sram_nway_if.slave bus
);

  typedef logic [WAYS-1:0][AGE_W-1:0] age_vec_t;

  line_t             meta_q [SETS][WAYS];
  logic [LINE_W-1:0] data_q [SETS][WAYS];
  age_vec_t          age_q  [SETS];

  logic [IDX_W-1:0]   set;
  logic [TAG_MAX-1:0] tag_x;
  logic [WAYS-1:0]    match;
  logic               hit;
  logic [AGE_W-1:0]   hit_way;
  logic [AGE_W-1:0]   vic_way;
  logic [AGE_W-1:0]   oldest;
  logic [AGE_W-1:0]   sel;
  logic               touch;
  age_vec_t           age_nxt;

  assign set   = bus.addr_i;
  assign tag_x = TAG_MAX'(bus.tag_i);

  // Valid-gated tag compare on every way of the addressed set.
  always_comb begin
    match = '0;
    for (int w = 0; w < WAYS; w++)
      match[w] = meta_q[set][w].valid &&
                 (meta_q[set][w].tag == tag_x);
  end

  // Hit way encode; victim is lowest invalid way, else the oldest.
  always_comb begin
    hit_way = '0;
    vic_way = oldest;
    for (int w = 0; w < WAYS; w++)
      if (match[w]) hit_way = AGE_W'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!meta_q[set][w].valid) vic_way = AGE_W'(w);
  end

  assign hit   = |match;
  assign sel   = hit ? hit_way : vic_way;
  assign touch = bus.enable_i && (hit || bus.write_i);

  assign bus.hit_o   = hit;
  assign bus.way_o   = sel;
  assign bus.tag_o   = meta_q[set][sel].tag[TAG_W-1:0];
  assign bus.data_o  = data_q[set][sel];
  assign bus.valid_o = meta_q[set][sel].valid;
  assign bus.dirty_o = meta_q[set][sel].dirty;

  dcache_lru_age #(
    .WAYS (WAYS)
  ) u_lru (
    .age_i    (age_q[set]),
    .way_i    (sel),
    .touch_i  (touch),
    .age_o    (age_nxt),
    .oldest_o (oldest)
  );

  // Array state: reset clears lines and restores age order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          meta_q[s][w] <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= AGE_W'(WAYS - 1 - w);
        end
      end
    end else if (bus.enable_i) begin
      if (touch)
        age_q[set] <= age_nxt;
      if (bus.write_i) begin
        data_q[set][sel] <= bus.data_i;
        if (hit) begin
          meta_q[set][sel].dirty <=
            meta_q[set][sel].dirty | bus.dirty_i;
        end else begin
          meta_q[set][sel].valid <= 1'b1;
          meta_q[set][sel].dirty <= bus.dirty_i;
          meta_q[set][sel].tag   <= tag_x;
        end
      end
    end
  end

endmodule

// File: tb/tb_dcache_sram_nway.sv
// dcache_sram_nway bench: directed scenarios then random traffic.
// Reference keeps a per-set recency list instead of age counters.
module tb_dcache_sram_nway;

  localparam int SETS   = 16;
  localparam int WAYS   = 4;
  localparam int TAG_W  = 25;
  localparam int LINE_W = 256;

  typedef logic [LINE_W-1:0] val_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dcache_sram_nway_if #(
    .SETS(SETS), .WAYS(WAYS),
    .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) bus ();

  dcache_sram_nway #(
    .SETS(SETS), .WAYS(WAYS),
    .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic              m_valid [SETS][WAYS];
  logic              m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag   [SETS][WAYS];
  logic [LINE_W-1:0] m_data  [SETS][WAYS];
  int                m_ord   [SETS][WAYS];

  logic              o_hit;
  logic [1:0]        o_way;
  logic [TAG_W-1:0]  o_tag;
  logic [LINE_W-1:0] o_data;
  logic              o_dirty;
  logic              o_valid;

  task automatic check(input string name,
                       input val_t got,
                       input val_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_tag[s][w]   = '0;
        m_data[s][w]  = '0;
        m_ord[s][w]   = WAYS - 1 - w;
      end
  endtask

  function automatic int rank(input int s, input int w);
    int r = 0;
    for (int i = 0; i < WAYS; i++)
      if (m_ord[s][i] == w) r = i;
    return r;
  endfunction

  task automatic model_touch(input int s, input int k);
    int r = rank(s, k);
    for (int i = r; i > 0; i--)
      m_ord[s][i] = m_ord[s][i-1];
    m_ord[s][0] = k;
  endtask

  task automatic predict(input int s,
                         input logic [TAG_W-1:0] t,
                         output logic h,
                         output int way);
    h   = 1'b0;
    way = m_ord[s][WAYS-1];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[s][w]) way = w;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) begin
        h   = 1'b1;
        way = w;
      end
  endtask

  task automatic check_ages();
    val_t e = '0;
    val_t g = '0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        e[(s*WAYS+w)*2 +: 2] = 2'(rank(s, w));
        g[(s*WAYS+w)*2 +: 2] = dut.age_q[s][w];
      end
    check("age", g, e);
  endtask

  function automatic val_t rand_line();
    val_t v;
    for (int i = 0; i < LINE_W / 32; i++)
      v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic access(input logic en,
                        input logic wr,
                        input int s,
                        input logic [TAG_W-1:0] t,
                        input val_t d,
                        input logic dy);
    logic h;
    int w;
    @(negedge clk);
    bus.enable_i = en;
    bus.write_i  = wr;
    bus.addr_i   = 4'(s);
    bus.tag_i    = t;
    bus.data_i   = d;
    bus.dirty_i  = dy;
    #1;
    check_ages();
    predict(s, t, h, w);
    o_hit   = bus.hit_o;
    o_way   = bus.way_o;
    o_tag   = bus.tag_o;
    o_data  = bus.data_o;
    o_dirty = bus.dirty_o;
    o_valid = bus.valid_o;
    check("hit", val_t'(o_hit), val_t'(h));
    check("way", val_t'(o_way), val_t'(w));
    check("valid", val_t'(o_valid), val_t'(m_valid[s][w]));
    check("dirty", val_t'(o_dirty), val_t'(m_dirty[s][w]));
    check("tag", val_t'(o_tag), val_t'(m_tag[s][w]));
    check("data", o_data, m_data[s][w]);
    @(posedge clk);
    if (en) begin
      if (h) begin
        if (wr) begin
          m_data[s][w]  = d;
          m_dirty[s][w] = m_dirty[s][w] | dy;
        end
        model_touch(s, w);
      end else if (wr) begin
        m_valid[s][w] = 1'b1;
        m_dirty[s][w] = dy;
        m_tag[s][w]   = t;
        m_data[s][w]  = d;
        model_touch(s, w);
      end
    end
  endtask

  val_t p55;
  logic ph;
  int   pv;

  initial begin
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    bus.addr_i   = '0;
    bus.tag_i    = '0;
    bus.data_i   = '0;
    bus.dirty_i  = 1'b0;
    model_reset();
    #12 rst = 1'b0;

    access(1'b1, 1'b0, 3, 25'h0, '0, 1'b0);
    check("rst_hit", val_t'(o_hit), val_t'(0));
    check("rst_valid", val_t'(o_valid), val_t'(0));
    check("rst_way", val_t'(o_way), val_t'(0));

    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b1, 5, TAG_W'(10 + i),
             val_t'(32'h1000 + i), 1'b0);
      check("fill_way", val_t'(o_way), val_t'(i));
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, 5, TAG_W'(10 + i), '0, 1'b0);
      check("fill_hit", val_t'(o_hit), val_t'(1));
      check("fill_data", o_data, val_t'(32'h1000 + i));
    end

    access(1'b1, 1'b0, 5, 25'hA, '0, 1'b0);
    access(1'b1, 1'b1, 5, 25'hE, val_t'(32'hE0), 1'b0);
    check("vic_way", val_t'(o_way), val_t'(1));
    check("vic_tag", val_t'(o_tag), val_t'(25'hB));
    check("vic_dirty", val_t'(o_dirty), val_t'(0));
    access(1'b1, 1'b0, 5, 25'hB, '0, 1'b0);
    check("evicted", val_t'(o_hit), val_t'(0));
    access(1'b1, 1'b0, 5, 25'hE, '0, 1'b0);
    check("new_hit", val_t'(o_hit), val_t'(1));
    check("new_way", val_t'(o_way), val_t'(1));

    p55 = {64{4'h5}};
    access(1'b1, 1'b1, 5, 25'hC, p55, 1'b1);
    access(1'b1, 1'b1, 5, 25'hC, p55, 1'b0);
    access(1'b1, 1'b0, 5, 25'hC, '0, 1'b0);
    check("sticky_dirty", val_t'(o_dirty), val_t'(1));
    check("wr_data", o_data, p55);

    predict(5, 25'h7, ph, pv);
    access(1'b1, 1'b0, 5, 25'h7, '0, 1'b0);
    check("miss_hit", val_t'(o_hit), val_t'(0));
    access(1'b1, 1'b1, 5, 25'h8, val_t'(32'h88), 1'b0);
    check("miss_lru", val_t'(o_way), val_t'(pv));

    @(negedge clk);
    bus.enable_i = 1'b1;
    bus.write_i  = 1'b1;
    bus.addr_i   = 4'd6;
    bus.tag_i    = 25'hF;
    bus.data_i   = val_t'(32'hF0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.enable_i = 1'b0;
    model_reset();
    access(1'b1, 1'b0, 6, 25'hF, '0, 1'b0);
    check("rst_fill", val_t'(o_hit), val_t'(0));
    access(1'b1, 1'b0, 5, 25'hE, '0, 1'b0);
    check("rst_line", val_t'(o_valid), val_t'(0));

    for (int n = 0; n < 600; n++) begin
      access(1'($urandom_range(0, 7) != 0),
             1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)),
             TAG_W'($urandom_range(0, 6)),
             rand_line(),
             1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    check_ages();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_sram_nway.md
Name: dcache_sram_nway

Overview:
- Parametrised N-way set-associative data-cache storage array with true-LRU replacement via per-way age counters, plus per-line valid and dirty bits.
- Lookup is combinational, same cycle. All state updates happen on clk_i.
- On a miss it presents the LRU victim's tag, data and dirty bit so the dcache controller can write back before refill.
- Sits between the dcache controller FSM and the data memory interface.

Parameters:
- SETS, 16, number of sets (power of two, >=2)
- WAYS, 2, associativity (power of two, 2..8)
- TAG_W, 25, tag width in bits
- LINE_W, 256, cache line width in bits
- IDX_W, $clog2(SETS), set index width (derived, not overridable)
- AGE_W, $clog2(WAYS), age counter width (derived)

Ports:
- clk_i, in, 1, clock
- rst_i, in, 1, asynchronous active-high reset
- addr_i, in, IDX_W, set index
- tag_i, in, TAG_W, lookup/fill tag
- data_i, in, LINE_W, write/fill line
- enable_i, in, 1, access valid this cycle
- write_i, in, 1, 1 = write (hit update or miss fill), 0 = read
- dirty_i, in, 1, dirty value applied on write
- hit_o, out, 1, valid way with matching tag exists in addr_i set
- way_o, out, AGE_W, hit way on hit, victim way on miss
- tag_o, out, TAG_W, hit tag on hit, victim tag on miss
- data_o, out, LINE_W, hit line on hit, victim line on miss
- valid_o, out, 1, valid bit of the selected way
- dirty_o, out, 1, dirty bit of the selected way

Behaviour:
- Reset, asynchronous:
  - all valid=0, dirty=0, tags=0, data=0
  - age[s][w]=WAYS-1-w, so way 0 is the oldest
  - outputs then follow combinationally: hit_o=0, valid_o=0, dirty_o=0, way_o=0, tag_o=0, data_o=0.
- Hit: hit_o = OR over w of (valid[s][w] && tag[s][w]==tag_i). At most one way can match, guaranteed by the fill rule.
- Victim select, priority order:
  - lowest-index invalid way, if any;
  - otherwise the way with age == WAYS-1.
- Outputs are purely combinational from the current array state. A write is visible on outputs the cycle after the clock edge.
- Age update (touch way k in set s), single clock edge:
  - every way w in s with age[s][w] < age[s][k] increments;
  - age[s][k] becomes 0;
  - other ways and other sets are unchanged.
  - Ages in each set remain a permutation of 0..WAYS-1 at all times. The bench checks this invariant every cycle.
- enable_i=1, write_i=0, hit: touch the hit way. No data, tag, valid or dirty change.
- enable_i=1, write_i=0, miss: no state change. The read miss does not disturb LRU; the controller follows with a fill write.
- enable_i=1, write_i=1, hit:
  - data[hit way] = data_i;
  - dirty |= dirty_i (never cleared by a hit write);
  - touch the hit way.
- enable_i=1, write_i=1, miss (fill):
  - victim way v gets tag=tag_i, data=data_i, valid=1, dirty=dirty_i;
  - touch v.
  - Victim outputs seen before the edge reflect the evicted line, so writeback data is available in the same cycle as the fill decision.
- enable_i=0: no state change, regardless of write_i. Outputs still reflect lookup for addr_i/tag_i.
- Reset asserted mid-access: reset wins. Any pending write in that cycle is discarded.
- Back-to-back accesses to the same set: each cycle sees the state committed by the previous edge. No forwarding is required or provided.
- tag_i=0 on a reset (invalid) line must not hit, because valid gates the match.

Decomposition:
- Package dcache_pkg holds:
  - default SETS, WAYS, TAG_W, LINE_W localparams;
  - a line-state struct {valid, dirty, tag}.
- Sub-module dcache_lru_age, parametrised by WAYS:
  - input: packed age vector of one set, touch way, touch enable;
  - output: next age vector and oldest-way index;
  - combinational;
  - instantiated once on the addressed set.
- The top holds the arrays, the hit comparators, the victim priority encoder and the sequential writes.

Test Plan (SETS=16, WAYS=4, TAG_W=25, LINE_W=256):
- Reset, then read set 3 with tag 0x0 -> hit_o=0, valid_o=0, way_o=0.
- Fill set 5 with tags 0xA, 0xB, 0xC, 0xD (dirty_i=0) -> ways 0, 1, 2, 3 in order; reading each tag gives hit_o=1 and the matching way_o and data.
- After that fill, read-hit 0xA, then fill 0xE -> victim is way 1 (tag 0xB, oldest). Before the edge: tag_o=0xB, dirty_o=0. Afterwards 0xB misses and 0xE hits in way 1.
- Write-hit 0xC with dirty_i=1 and data 0x55..55, then write-hit 0xC with dirty_i=0 -> dirty_o stays 1 and data_o=0x55..55.
- Read miss tag 0x7 on a full set -> ages unchanged, checked by a subsequent fill that evicts the same victim as predicted before the miss.
- Assert rst_i for a partial cycle during a write-miss fill -> no fill; all lines invalid; ages back to the reset permutation.
